// File: rtl/ej3_pkg.sv
// Shared definitions for the EJ3 sequence detector: the 3-bit state encoding.
package ej3_pkg;

    typedef enum logic [2:0] {
        S0 = 3'd0,  // idle, no useful prefix
        S1 = 3'd1,  // seen "1"
        S2 = 3'd2,  // seen "10"
        S3 = 3'd3,  // seen "100"
        S4 = 3'd4   // seen "1001", detect
    } state_t;

endpackage

// File: rtl/ej3a_fsm.sv
// Moore detector for the serial pattern 1001 on w, with overlap.
// out is decoded from the state register only.
module ej3a_fsm
    import ej3_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic w,
    output logic out
);

    state_t state;
    state_t state_next;

    always_ff @(posedge clk) begin
        if (reset)
            state <= S0;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = S0;
        case (state)
            S0: state_next = w ? S1 : S0;
            S1: state_next = w ? S1 : S2;
            S2: state_next = w ? S1 : S3;
            S3: state_next = w ? S4 : S0;
            // The trailing 1 of a match doubles as the next prefix.
            S4: state_next = w ? S1 : S2;
            default: state_next = S0;
        endcase
    end

    assign out = (state == S4);

endmodule

// File: tb/tb_ej3a_fsm.sv
// Directed table-driven bench for ej3a_fsm, plus an illegal-state recovery check.
module tb_ej3a_fsm;
    import ej3_pkg::*;

    logic clk;
    logic reset;
    logic w;
    logic out;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic rst;
        logic w;
        logic exp_out;
    } vec_t;

    vec_t vecs[$];

    ej3a_fsm dut (
        .clk   (clk),
        .reset (reset),
        .w     (w),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic add(input logic r, input logic wb, input logic e);
        vec_t v;
        v.rst = r;
        v.w = wb;
        v.exp_out = e;
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b1;
        w = 1'b1;

        // reset for two edges with w=1
        add(1, 1, 0); add(1, 1, 0);
        // basic match, then w=1 leaves S4 for S1
        add(0, 1, 0); add(0, 0, 0); add(0, 0, 0); add(0, 1, 1); add(0, 1, 0);
        // overlapping matches
        add(1, 0, 0);
        add(0, 1, 0); add(0, 0, 0); add(0, 0, 0); add(0, 1, 1);
        add(0, 0, 0); add(0, 0, 0); add(0, 1, 1);
        // near miss 1,0,1,0,0,0,1
        add(1, 0, 0);
        add(0, 1, 0); add(0, 0, 0); add(0, 1, 0); add(0, 0, 0);
        add(0, 0, 0); add(0, 0, 0); add(0, 1, 0);
        // near miss 1,1,0,0,0,1
        add(1, 0, 0);
        add(0, 1, 0); add(0, 1, 0); add(0, 0, 0); add(0, 0, 0);
        add(0, 0, 0); add(0, 1, 0);
        // 1,1,0,0,1 matches on the 5th edge
        add(1, 0, 0);
        add(0, 1, 0); add(0, 1, 0); add(0, 0, 0); add(0, 0, 0); add(0, 1, 1);
        // reset mid-sequence discards the prefix, then a fresh match
        add(1, 0, 0);
        add(0, 1, 0); add(0, 0, 0); add(0, 0, 0);
        add(1, 1, 0);
        add(0, 1, 0);
        add(0, 1, 0); add(0, 0, 0); add(0, 0, 0); add(0, 1, 1);
        add(0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst;
            w = vecs[i].w;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_out", i), {31'd0, out}, {31'd0, vecs[i].exp_out});
        end

        // Reset leaves the state register at S0.
        @(negedge clk);
        reset = 1'b1;
        w = 1'b1;
        @(posedge clk);
        #1;
        check("reset_state", {29'd0, dut.state}, {29'd0, S0});

        // Illegal encoding 6 must fall back to S0 on the next edge.
        @(negedge clk);
        reset = 1'b0;
        w = 1'b0;
        force dut.state = state_t'(3'd6);
        #1;
        check("illegal_out", {31'd0, out}, 32'd0);
        release dut.state;
        @(posedge clk);
        #1;
        check("illegal_state", {29'd0, dut.state}, {29'd0, S0});
        check("illegal_out_after", {31'd0, out}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
